// File: rtl/spi_ctrl_pkg.sv
// Shared types, constants and helpers for the SPI burst controller.
package spi_ctrl_pkg;

  localparam int RW_BIT = 7;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_HOLD,
    ST_RESP
  } state_e;

  // Header byte sent first on the wire: {rw, 5'b0, addr}.
  function automatic logic [7:0] addr_byte(input logic rw, input logic [ADDR_W-1:0] addr);
    logic [7:0] hdr;
    hdr             = '0;
    hdr[RW_BIT]     = rw;
    hdr[ADDR_W-1:0] = addr;
    return hdr;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Command/response bus between the register block (master) and the burst controller (slave).
interface spi_burst_ctrl_if;
  import spi_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_len;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/spi_cyc_timer.sv
// Loadable down-counter with a zero flag; load wins over the decrement.
module spi_cyc_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of SPI_Master for the 4-register SPI_Slave protocol.
// Optional per-byte watchdog enabled by defining SPI_TIMEOUT_EN.
module spi_burst_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int          SS_SETUP_CYC = 1,
  parameter int          GAP_CYC      = 1,
  parameter int          SS_HOLD_CYC  = 5,
  parameter logic [7:0]  DUMMY_BYTE   = 8'hFF,
  parameter int          TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  spi_burst_ctrl_if.slave   bus,
  output logic              CPOL,
  output logic              CPHA,
  output logic              m_start,
  output logic [7:0]        m_tx_data,
  input  logic [7:0]        m_rx_data,
  input  logic              m_done,
  input  logic              m_ready,
  output logic              SS
);

  localparam int MAX_CYC = max_int(max_int(SS_SETUP_CYC, GAP_CYC), max_int(SS_HOLD_CYC, TIMEOUT_CYC));
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // A state that waits n cycles is entered with n-1 loaded and leaves on zero.
  function automatic logic [TMR_W-1:0] cyc_load(input int n);
    return (n > 1) ? TMR_W'(n - 1) : '0;
  endfunction

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ss_q, ss_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic              last_byte;
  logic [1:0]        data_idx;

  assign last_byte = (idx_q == ({1'b0, len_q} + 3'd1));
  assign data_idx  = idx_q[1:0] - 2'd1;

`ifdef SPI_TIMEOUT_EN
  logic tmo_hit;
  logic err_q, err_d;
  assign tmo_hit = tmr_zero && (state_q inside {ST_ISSUE, ST_WAIT});
`endif

  spi_cyc_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.cmd_valid) state_d = ST_SETUP;
      ST_SETUP: if (tmr_zero) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (m_ready) state_d = ST_WAIT;
`ifdef SPI_TIMEOUT_EN
        if (tmo_hit) state_d = ST_HOLD;
`endif
      end
      ST_WAIT: begin
`ifdef SPI_TIMEOUT_EN
        if (tmo_hit) state_d = ST_HOLD;
`endif
        // A completed byte beats a simultaneous watchdog expiry.
        if (m_done) state_d = last_byte ? ST_HOLD : ST_GAP;
      end
      ST_GAP:   if (tmr_zero) state_d = ST_ISSUE;
      ST_HOLD:  if (tmr_zero) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    m_start       = (state_q == ST_ISSUE) && m_ready;
`ifdef SPI_TIMEOUT_EN
    if (tmo_hit) m_start = 1'b0;
`endif
    m_tx_data = '0;
    if (state_q inside {ST_ISSUE, ST_WAIT}) begin
      m_tx_data = (idx_q == '0) ? addr_byte(write_q, addr_q) :
                  write_q       ? wdata_q[{data_idx, 3'b000} +: 8] : DUMMY_BYTE;
    end
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_SETUP: tmr_val = cyc_load(SS_SETUP_CYC);
      ST_GAP:   tmr_val = cyc_load(GAP_CYC);
      ST_HOLD:  tmr_val = cyc_load(SS_HOLD_CYC);
`ifdef SPI_TIMEOUT_EN
      ST_ISSUE, ST_WAIT: tmr_val = cyc_load(TIMEOUT_CYC);
`endif
      default:  tmr_val = '0;
    endcase
  end

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    if (state_q == ST_IDLE && bus.cmd_valid) begin
      write_d = bus.cmd_write;
      addr_d  = bus.cmd_addr;
      len_d   = bus.cmd_len;
      wdata_d = bus.cmd_wdata;
      idx_d   = '0;
      rdata_d = '0;
    end
    if (state_q == ST_WAIT && m_done) begin
      // The rx byte clocked in during the header is meaningless and dropped.
      if (!write_q && idx_q != '0) rdata_d[{data_idx, 3'b000} +: 8] = m_rx_data;
      if (!last_byte) idx_d = idx_q + 3'd1;
    end
    ss_d = !(state_d inside {ST_SETUP, ST_ISSUE, ST_WAIT, ST_GAP, ST_HOLD});
`ifdef SPI_TIMEOUT_EN
    err_d = err_q;
    if (state_q == ST_IDLE && bus.cmd_valid) err_d = 1'b0;
    if ((state_q == ST_ISSUE && tmo_hit) || (state_q == ST_WAIT && tmo_hit && !m_done)) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      ss_q    <= 1'b1;
`ifdef SPI_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      ss_q    <= ss_d;
`ifdef SPI_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign CPOL          = 1'b0;
  assign CPHA          = 1'b0;
  assign SS            = ss_q;
  assign bus.rsp_rdata = rdata_q;
`ifdef SPI_TIMEOUT_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
